w_update_bank: RTL and testbench

Parametrised multi-tap LMS/FLAF weight-update bank. It updates TAPS weights in parallel from one shared mu*error term and a per-tap input vector. It extends the single-tap updater with:
- pipelined valid handshake
- per-update freeze
- parallel weight preload
- optional saturation, with a sticky overflow flag

It sits between the error/step-size stage and the FIR/FLAF tap multipliers.

---
 rtl/w_update_bank.sv | 98 +++++++++
 tb/tb_w_update_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_update_bank.sv
// Multi-tap LMS/FLAF weight-update bank: two-stage pipeline (tap products, then weight accumulate)
// with per-update freeze, parallel preload and optional saturation with a sticky overflow flag.
module w_update_bank #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned QP    = 12,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned TAPS  = 8,
   parameter int unsigned SAT   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [WIDTH-1:0]        mu_error,
   input  logic [TAPS*WIDTH-1:0]   x_vec,
   input  logic                    freeze,
   input  logic                    load_en,
   input  logic [TAPS*WIDTH-1:0]   load_data,
   input  logic                    sat_clr,
   output logic [TAPS*WIDTH-1:0]   weights,
   output logic                    out_valid,
   output logic                    sat_flag
);

   localparam int unsigned    PW     = 2 * WIDTH;
   localparam int unsigned    RS     = QP + SHIFT;
   localparam logic [PW-1:0]  RND    = PW'(1) << (RS - 1);
   localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
   localparam bit             SAT_EN = (SAT != 0);

   logic signed [WIDTH-1:0] mu_s;
   logic [TAPS*WIDTH-1:0]   inc_c;
   logic [TAPS*WIDTH-1:0]   inc_q;
   logic [TAPS*WIDTH-1:0]   next_w_c;
   logic [TAPS-1:0]         ovf_c;
   logic                    v1;
   logic                    f1;
   logic                    wr_c;

   assign mu_s = mu_error;
   assign wr_c = v1 && !f1 && !load_en;

   // Per-tap rounded increment and saturating/wrapping accumulate
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      logic signed [WIDTH-1:0] x_s;
      logic signed [WIDTH-1:0] w_s;
      logic signed [WIDTH-1:0] inc_s;
      logic signed [PW-1:0]    prod;
      logic [PW-1:0]           rnd;
      logic signed [WIDTH:0]   sum;

      assign x_s   = x_vec[k*WIDTH +: WIDTH];
      assign prod  = PW'(x_s) * PW'(mu_s);
      assign rnd   = prod + RND;
      assign inc_c[k*WIDTH +: WIDTH] = rnd[RS +: WIDTH];

      assign w_s   = weights[k*WIDTH +: WIDTH];
      assign inc_s = inc_q[k*WIDTH +: WIDTH];
      assign sum   = (WIDTH+1)'(w_s) + (WIDTH+1)'(inc_s);
      assign ovf_c[k] = sum[WIDTH] ^ sum[WIDTH-1];
      assign next_w_c[k*WIDTH +: WIDTH] = (SAT_EN && ovf_c[k]) ? (sum[WIDTH] ? MIN_W : MAX_W)
                                                               : sum[WIDTH-1:0];
   end

   // Stage 1: a load also kills the entry being registered so it cannot land on preloaded weights
   always_ff @(posedge clk) begin : stage1_reg
      if (reset) begin
         v1 <= 1'b0;
         f1 <= 1'b0;
      end else begin
         v1 <= in_valid && !load_en;
         f1 <= in_valid && freeze;
      end
      inc_q <= inc_c;
   end

   // Stage 2: weights, completion pulse and sticky overflow (set beats clear)
   always_ff @(posedge clk) begin : stage2_reg
      if (reset) begin
         weights   <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= wr_c;
         if (load_en) begin
            weights <= load_data;
         end else if (wr_c) begin
            weights <= next_w_c;
         end
         if (wr_c && (|ovf_c)) begin
            sat_flag <= 1'b1;
         end else if (sat_clr) begin
            sat_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_w_update_bank.sv
// Bench for w_update_bank: three instances (SAT=1/SHIFT=0, SAT=0/SHIFT=0, SAT=1/SHIFT=1) share stimulus
// and are checked against an arithmetic reference model, plus directed vectors on the first instance.
module tb_w_update_bank;

   localparam int unsigned W = 16;
   localparam int unsigned T = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            iv = 1'b0;
   logic            fz = 1'b0;
   logic            ld = 1'b0;
   logic            sc = 1'b0;
   logic [W-1:0]    mu = '0;
   logic [T*W-1:0]  xv = '0;
   logic [T*W-1:0]  ldv = '0;
   logic [T*W-1:0]  w_o  [3];
   logic            ov_o [3];
   logic            sf_o [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   w_update_bank #(.WIDTH(16), .QP(12), .SHIFT(0), .TAPS(4), .SAT(1)) u_a (
      .clk(clk), .reset(rst), .in_valid(iv), .mu_error(mu), .x_vec(xv), .freeze(fz),
      .load_en(ld), .load_data(ldv), .sat_clr(sc), .weights(w_o[0]), .out_valid(ov_o[0]),
      .sat_flag(sf_o[0]));
   w_update_bank #(.WIDTH(16), .QP(12), .SHIFT(0), .TAPS(4), .SAT(0)) u_b (
      .clk(clk), .reset(rst), .in_valid(iv), .mu_error(mu), .x_vec(xv), .freeze(fz),
      .load_en(ld), .load_data(ldv), .sat_clr(sc), .weights(w_o[1]), .out_valid(ov_o[1]),
      .sat_flag(sf_o[1]));
   w_update_bank #(.WIDTH(16), .QP(12), .SHIFT(1), .TAPS(4), .SAT(1)) u_c (
      .clk(clk), .reset(rst), .in_valid(iv), .mu_error(mu), .x_vec(xv), .freeze(fz),
      .load_en(ld), .load_data(ldv), .sat_clr(sc), .weights(w_o[2]), .out_valid(ov_o[2]),
      .sat_flag(sf_o[2]));

   // Reference model: integer arithmetic on sampled inputs, one pending update in flight
   int  shf  [3] = '{0, 0, 1};
   bit  satm [3] = '{1'b1, 1'b0, 1'b1};
   int  mw   [3][T];
   bit  msf  [3];
   bit  mov  [3];
   bit  pv = 1'b0;
   bit  pf = 1'b0;
   int  px   [T];
   int  pmu = 0;

   function automatic int sx16(input logic [15:0] v);
      logic signed [15:0] t;
      t = v;
      return int'(t);
   endfunction

   function automatic int wrap16(input longint v);
      logic [15:0] t;
      t = 16'(v);
      return sx16(t);
   endfunction

   task automatic model_step();
      bit wr;
      bit any_ov;
      longint prod, r, s;
      int inc;
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < T; k++) mw[d][k] = 0;
            msf[d] = 1'b0;
            mov[d] = 1'b0;
         end
         pv = 1'b0;
      end else begin
         wr = pv && !pf && !ld;
         for (int d = 0; d < 3; d++) begin
            any_ov = 1'b0;
            for (int k = 0; k < T; k++) begin
               if (ld) begin
                  mw[d][k] = sx16(ldv[k*W +: W]);
               end else if (wr) begin
                  prod = longint'(px[k]) * longint'(pmu);
                  r    = (prod + (longint'(1) << (11 + shf[d]))) >>> (12 + shf[d]);
                  inc  = wrap16(r);
                  s    = longint'(mw[d][k]) + longint'(inc);
                  if (s > 32767 || s < -32768) begin
                     any_ov = 1'b1;
                     if (satm[d]) s = (s > 0) ? 32767 : -32768;
                  end
                  mw[d][k] = wrap16(s);
               end
            end
            if (wr && any_ov) msf[d] = 1'b1;
            else if (sc)      msf[d] = 1'b0;
            mov[d] = wr;
         end
         pv = iv && !ld;
      end
      pf  = fz;
      pmu = sx16(mu);
      for (int k = 0; k < T; k++) px[k] = sx16(xv[k*W +: W]);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mvec(input int d);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < T; k++) v[k*W +: W] = 16'(mw[d][k]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("model_w[%0d]", d), w_o[d], mvec(d));
         chk($sformatf("model_ov[%0d]", d), 64'(ov_o[d]), 64'(mov[d]));
         chk($sformatf("model_sf[%0d]", d), 64'(sf_o[d]), 64'(msf[d]));
      end
   endtask

   task automatic set_in(input logic r, input logic v, input logic f, input logic l, input logic c,
                         input logic [15:0] m, input logic [15:0] x0, input logic [15:0] xo,
                         input logic [15:0] lv);
      rst = r; iv = v; fz = f; ld = l; sc = c; mu = m;
      xv  = {xo, xo, xo, x0};
      ldv = {lv, lv, lv, lv};
   endtask

   typedef struct {
      logic        r, v, f, l, c;
      logic [15:0] m, x0, xo, lv;
      logic [15:0] ew0, ew1;
      logic        eov, esf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic v, input logic f, input logic l,
                               input logic c, input logic [15:0] m, input logic [15:0] x0,
                               input logic [15:0] xo, input logic [15:0] lv,
                               input logic [15:0] ew0, input logic [15:0] ew1,
                               input logic eov, input logic esf);
      vec_t e;
      e.r = r; e.v = v; e.f = f; e.l = l; e.c = c;
      e.m = m; e.x0 = x0; e.xo = xo; e.lv = lv;
      e.ew0 = ew0; e.ew1 = ew1; e.eov = eov; e.esf = esf;
      return e;
   endfunction

   initial begin
      //                 r  v  f  l  c  mu       x0       xo       ldv      ew0      ew1      ov sf
      // basic update
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0800, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 0, 0));
      // negative rounding
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0001, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 0));
      // back-to-back pipeline
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0100, 16'h0100, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0200, 16'h0200, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0300, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0300, 0, 0));
      // middle update frozen
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0100, 16'h0100, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0100, 16'h0100, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0200, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0200, 0, 0));
      // load collisions
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0100, 16'h1000, 16'h1000, 16'h1234, 16'h1234, 16'h1234, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0, 0));
      // reset mid-pipeline
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 0, 0));
      // saturation with sticky flag
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h7F00, 16'h7F00, 16'h7F00, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0200, 16'h1000, 16'h1000, 16'h0000, 16'h7F00, 16'h7F00, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));

      foreach (tbl[i]) begin
         set_in(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].c, tbl[i].m, tbl[i].x0, tbl[i].xo,
                tbl[i].lv);
         tick();
         chk($sformatf("vec%0d_w", i), w_o[0], {tbl[i].ew1, tbl[i].ew1, tbl[i].ew1, tbl[i].ew0});
         chk($sformatf("vec%0d_ov", i), 64'(ov_o[0]), 64'(tbl[i].eov));
         chk($sformatf("vec%0d_sf", i), 64'(sf_o[0]), 64'(tbl[i].esf));
      end

      // SHIFT=1 rounds half up: 0x1000*1 / 2^13 = 0.5 -> 1
      set_in(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      set_in(0, 1, 0, 0, 0, 16'h0001, 16'h1000, 16'h0000, 16'h0000); tick();
      set_in(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      chk("shift1_round", w_o[2], 64'h0000_0000_0000_0001);
      chk("shift0_round", w_o[0], 64'h0000_0000_0000_0001);

      // wrap mode overflow, then set-beats-clear on the sticky flag
      set_in(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      set_in(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h7F00); tick();
      set_in(0, 1, 0, 0, 0, 16'h0200, 16'h1000, 16'h1000, 16'h0000); tick();
      set_in(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      chk("wrap_w", w_o[1], {4{16'h8100}});
      chk("wrap_sf", 64'(sf_o[1]), 64'd1);
      chk("sat_w", w_o[0], {4{16'h7FFF}});
      set_in(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      chk("clr_sf", 64'(sf_o[0]), 64'd0);
      set_in(0, 1, 0, 0, 0, 16'h0200, 16'h1000, 16'h1000, 16'h0000); tick();
      set_in(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000); tick();
      chk("set_beats_clr", 64'(sf_o[0]), 64'd1);
      chk("wrap_no_ovf_sf", 64'(sf_o[1]), 64'd0);
      chk("wrap_w2", w_o[1], {4{16'h8300}});

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         ld  = ($urandom_range(0, 11) == 0);
         sc  = ($urandom_range(0, 9) == 0);
         iv  = ($urandom_range(0, 3) != 0);
         fz  = ($urandom_range(0, 4) == 0);
         mu  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
         xv  = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
         ldv = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
